// File: rtl/q_frag_readback.sv
// Readback engine for a bank of Q_FRAG flops: snapshots AQZ and streams it out LSB first over SVLD/SRDY.
// Optional trailing even-parity bit when Q_FRAG_READBACK_PARITY_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for CAP; outputs quiet
// S_SHIFT | SVLD high, SDO = shadow[0], one bit per SVLD&&SRDY edge
// S_FIN   | one-cycle DONE pulse, then back to S_IDLE
module q_frag_readback #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             CAP,
  input  logic [WIDTH-1:0] AQZ,
  input  logic             SRDY,
  output logic             SDO,
  output logic             SVLD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

`ifdef Q_FRAG_READBACK_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             svld_q, svld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;

  assign xfer = svld_q && SRDY;

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      svld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      svld_q   <= svld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (CAP) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
`ifdef Q_FRAG_READBACK_PARITY_EN
          shadow_d = {^AQZ, AQZ};
`else
          shadow_d = AQZ;
`endif
        end
      end
      S_SHIFT: begin
        if (xfer) begin
          shadow_d = shadow_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == LAST_CNT) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    svld_d = (state_d == S_SHIFT);
    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
    err_d  = CAP && (state_q != S_IDLE);
  end

  assign SDO  = shadow_q[0];
  assign SVLD = svld_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_q_frag_readback.sv
// Directed bench for q_frag_readback: table of stream vectors plus reset and busy-capture sequences.
module tb_q_frag_readback;
  localparam int W = 8;
`ifdef Q_FRAG_READBACK_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         qrt, cap, srdy;
  logic [W-1:0] aqz;
  logic         sdo, svld, busy, done, err;
  int           total = 0;
  int           bad = 0;
  logic         err_exp = 1'b0;

  always #5 clk = ~clk;

  q_frag_readback #(.WIDTH(W)) dut (
    .QCK (clk),
    .QRT (qrt),
    .CAP (cap),
    .AQZ (aqz),
    .SRDY(srdy),
    .SDO (sdo),
    .SVLD(svld),
    .BUSY(busy),
    .DONE(done),
    .ERR (err)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // exp_left lists the emitted bits in time order, first bit leftmost.
  typedef struct {
    logic [7:0]  aqz;
    logic [15:0] srdy_pat;
    logic [7:0]  exp_left;
    logic        exp_par;
    int          busy_cap;
  } vec_t;

  vec_t vecs[7];

  // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_stream(input vec_t v);
    int   k;
    int   cyc;
    logic bit_exp;
    logic cap_now;
    aqz  = v.aqz;
    cap  = 1'b1;
    srdy = 1'b0;
    @(negedge clk);
    cap     = 1'b0;
    err_exp = 1'b0;
    chk("busy_start", busy, 1'b1);
    k   = 0;
    cyc = 0;
    while (k < NB && cyc < 64) begin
      bit_exp = (k < W) ? v.exp_left[W-1-k] : v.exp_par;
      chk("svld_stream", svld, 1'b1);
      chk("sdo_bit", sdo, bit_exp);
      chk("done_early", done, 1'b0);
      chk("err_stream", err, err_exp);
      cap_now = (cyc == v.busy_cap);
      cap     = cap_now;
      if (cap_now) aqz = ~v.aqz;
      err_exp = cap_now;
      srdy    = v.srdy_pat[cyc % 16];
      if (srdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < NB) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: transfers %0d expected %0d", k, NB);
    end
    cap  = 1'b0;
    srdy = 1'b0;
    chk("svld_fin", svld, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("busy_fin", busy, 1'b1);
    chk("err_fin", err, err_exp);
    err_exp = 1'b0;
    @(negedge clk);
    chk("done_clear", done, 1'b0);
    chk("busy_clear", busy, 1'b0);
    chk("svld_idle", svld, 1'b0);
    chk("err_idle", err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 16'hFFFF, 8'b10100101, 1'b0, -1};
    vecs[1] = '{8'h3C, 16'h9999, 8'b00111100, 1'b0, -1};
    vecs[2] = '{8'hFF, 16'hFFFF, 8'b11111111, 1'b0, 2};
    vecs[3] = '{8'h01, 16'hFFFF, 8'b10000000, 1'b1, -1};
    vecs[4] = '{8'hC8, 16'h5555, 8'b00010011, 1'b1, -1};
    vecs[5] = '{8'h07, 16'hFFFF, 8'b11100000, 1'b1, -1};
    vecs[6] = '{8'h03, 16'h3333, 8'b11000000, 1'b0, -1};

    qrt  = 1'b1;
    cap  = 1'b0;
    srdy = 1'b0;
    aqz  = '0;
    repeat (2) @(negedge clk);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_svld", svld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    qrt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_sdo", sdo, 1'b0);
      chk("idle_svld", svld, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_err", err, 1'b0);
    end

    for (int i = 0; i < 7; i++) run_stream(vecs[i]);

    // Reset after three transfers abandons the stream with no DONE.
    aqz = 8'hA5;
    cap = 1'b1;
    @(negedge clk);
    cap  = 1'b0;
    srdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_svld", svld, 1'b1);
    chk("mid_sdo", sdo, 1'b0);
    qrt = 1'b1;
    @(negedge clk);
    qrt  = 1'b0;
    srdy = 1'b0;
    chk("abort_svld", svld, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sdo", sdo, 1'b0);
    @(negedge clk);
    chk("abort_done2", done, 1'b0);
    chk("abort_busy2", busy, 1'b0);
    run_stream(vecs[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
